// File: rtl/uart_rx_controller.sv
// UART RX frame sequencer: counts oversampling edges and frame bits, drives RX datapath enables.
// Optional RX_ERR_STATUS_EN adds sticky per-frame par_err_o / frame_err_o outputs.
module uart_rx_controller #(
    parameter int Data_width = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic       sampled_bit,
    input  logic       parity_error,
    output logic       sampler_enable,
    output logic       deser_enable,
    output logic       parity_checker_enable,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       data_valid
`ifdef RX_ERR_STATUS_EN
    ,
    output logic       par_err_o,
    output logic       frame_err_o
`endif
);

    localparam logic [3:0] DW = 4'(Data_width);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_ERR_CHK
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] edge_q, edge_d;
    logic [3:0] bit_q, bit_d;
    logic [5:0] last_q, last_d;
    logic       par_en_q, par_en_d;
    logic       stop_err_q, stop_err_d;
    logic       active, le, frame_start;
    logic [5:0] last_sel;

    // Unsupported ratios fall back to 8x oversampling.
    always_comb begin
        last_sel = 6'd7;
        if (Prescale == 6'd16) last_sel = 6'd15;
        if (Prescale == 6'd32) last_sel = 6'd31;
    end

    assign active = (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PARITY) || (state_q == S_STOP);
    assign le     = (edge_q == last_q);

    always_comb begin
        state_d               = state_q;
        edge_d                = edge_q;
        bit_d                 = bit_q;
        last_d                = last_q;
        par_en_d              = par_en_q;
        stop_err_d            = stop_err_q;
        deser_enable          = 1'b0;
        parity_checker_enable = 1'b0;
        data_valid            = 1'b0;
        frame_start           = 1'b0;
        if (active) edge_d = le ? 6'd0 : edge_q + 6'd1;
        unique case (state_q)
            S_IDLE: begin
                edge_d = 6'd0;
                if (!RX_IN) frame_start = 1'b1;
            end
            S_START: begin
                if (le) begin
                    if (sampled_bit) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (le) begin
                    deser_enable          = 1'b1;
                    parity_checker_enable = 1'b1;
                    if (bit_q < DW) begin
                        bit_d = bit_q + 4'd1;
                    end else begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                        bit_d   = DW + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (le) begin
                    parity_checker_enable = 1'b1;
                    state_d               = S_STOP;
                    bit_d                 = DW + 4'd2;
                end
            end
            S_STOP: begin
                if (le) begin
                    stop_err_d = ~sampled_bit;
                    state_d    = S_ERR_CHK;
                end
            end
            S_ERR_CHK: begin
                data_valid = !stop_err_q && !(par_en_q && parity_error);
                edge_d     = 6'd0;
                bit_d      = 4'd0;
                if (!RX_IN) frame_start = 1'b1;
                else        state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // The detecting cycle counts as edge 0 of the start bit.
        if (frame_start) begin
            state_d  = S_START;
            edge_d   = 6'd1;
            bit_d    = 4'd0;
            last_d   = last_sel;
            par_en_d = PAR_EN;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            edge_q     <= 6'd0;
            bit_q      <= 4'd0;
            last_q     <= 6'd0;
            par_en_q   <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            last_q     <= last_d;
            par_en_q   <= par_en_d;
            stop_err_q <= stop_err_d;
        end
    end

    assign sampler_enable = active;
    assign edge_cnt       = edge_q;
    assign bit_cnt        = bit_q;

`ifdef RX_ERR_STATUS_EN
    logic par_err_q, frame_err_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (state_q == S_ERR_CHK) begin
            par_err_q   <= par_en_q && parity_error;
            frame_err_q <= stop_err_q;
        end
    end

    assign par_err_o   = par_err_q;
    assign frame_err_o = frame_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed table-driven bench for uart_rx_controller.
// Frames are driven bit by bit; sampled_bit mirrors the intended bit value.
module tb_uart_rx_controller;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic       sampled_bit;
    logic       parity_error;
    logic       sampler_enable;
    logic       deser_enable;
    logic       parity_checker_enable;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       data_valid;
`ifdef RX_ERR_STATUS_EN
    logic       par_err_o;
    logic       frame_err_o;
`endif

    uart_rx_controller #(.Data_width(8)) dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .RX_IN                 (RX_IN),
        .PAR_EN                (PAR_EN),
        .Prescale              (Prescale),
        .sampled_bit           (sampled_bit),
        .parity_error          (parity_error),
        .sampler_enable        (sampler_enable),
        .deser_enable          (deser_enable),
        .parity_checker_enable (parity_checker_enable),
        .edge_cnt              (edge_cnt),
        .bit_cnt               (bit_cnt),
        .data_valid            (data_valid)
`ifdef RX_ERR_STATUS_EN
        ,
        .par_err_o             (par_err_o),
        .frame_err_o           (frame_err_o)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    int d_cnt = 0;
    int d_sum = 0;
    int p_cnt = 0;
    int p_sum = 0;
    int v_cnt = 0;

    always @(negedge CLK) begin
        if (deser_enable) begin
            d_cnt = d_cnt + 1;
            d_sum = d_sum + int'(bit_cnt);
        end
        if (parity_checker_enable) begin
            p_cnt = p_cnt + 1;
            p_sum = p_sum + int'(bit_cnt);
        end
        if (data_valid) v_cnt = v_cnt + 1;
    end

    typedef struct {
        logic [5:0] presc;
        int         plen;
        bit         par;
        logic [7:0] data;
        bit         perr;
        bit         stop;
        bit         b2b;
        bit         exp_dv;
        int         exp_pn;
        int         exp_ps;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic rx, input logic sb, input int p);
        RX_IN       = rx;
        sampled_bit = sb;
        repeat (p) @(posedge CLK);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int d0, ds0, p0, ps0, v0;
        d0  = d_cnt;
        ds0 = d_sum;
        p0  = p_cnt;
        ps0 = p_sum;
        v0  = v_cnt;
        PAR_EN       = v.par;
        Prescale     = v.presc;
        parity_error = v.perr;
        RX_IN        = 1'b0;
        sampled_bit  = 1'b0;
        @(posedge CLK);
        #1;
        // Scramble config after latch point; frame must not change.
        PAR_EN   = ~v.par;
        Prescale = (v.plen == 32) ? 6'd16 : 6'd32;
        repeat (v.plen - 1) @(posedge CLK);
        #1;
        chk("start_bitcnt", 32'(bit_cnt), 32'd1);
        chk("start_edge", 32'(edge_cnt), 32'd0);
        chk("start_samp", 32'(sampler_enable), 32'd1);
        for (int i = 0; i < 8; i++) send_bit(v.data[i], v.data[i], v.plen);
        if (v.par) send_bit(^v.data, ^v.data, v.plen);
        send_bit(v.stop, v.stop, v.plen);
        chk("errchk_dv", 32'(data_valid), 32'(v.exp_dv));
        chk("errchk_samp", 32'(sampler_enable), 32'd0);
        #5;
        chk("dv_count", 32'(v_cnt - v0), 32'(v.exp_dv));
        chk("deser_count", 32'(d_cnt - d0), 32'd8);
        chk("deser_bitsum", 32'(d_sum - ds0), 32'd36);
        chk("pce_count", 32'(p_cnt - p0), 32'(v.exp_pn));
        chk("pce_bitsum", 32'(p_sum - ps0), 32'(v.exp_ps));
        if (!v.b2b) begin
            RX_IN       = 1'b1;
            sampled_bit = 1'b1;
            repeat (4) @(posedge CLK);
            #1;
            chk("idle_edge", 32'(edge_cnt), 32'd0);
            chk("idle_bit", 32'(bit_cnt), 32'd0);
`ifdef RX_ERR_STATUS_EN
            chk("par_err_o", 32'(par_err_o), 32'(v.par & v.perr));
            chk("frame_err_o", 32'(frame_err_o), 32'(!v.stop));
`endif
        end
    endtask

    initial begin
        int d0, p0, v0;
        vecs[0] = '{6'd8,  8,  1'b1 ^ 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 8, 36};
        vecs[1] = '{6'd16, 16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 9, 45};
        vecs[2] = '{6'd16, 16, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 9, 45};
        vecs[3] = '{6'd8,  8,  1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 8, 36};
        vecs[4] = '{6'd8,  8,  1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8, 36};
        vecs[5] = '{6'd32, 32, 1'b0, 8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 8, 36};
        vecs[6] = '{6'd32, 32, 1'b0, 8'h34, 1'b0, 1'b1, 1'b0, 1'b1, 8, 36};
        vecs[7] = '{6'd5,  8,  1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 9, 45};
        vecs[8] = '{6'd16, 16, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 9, 45};

        RST          = 1'b0;
        RX_IN        = 1'b1;
        PAR_EN       = 1'b0;
        Prescale     = 6'd8;
        sampled_bit  = 1'b1;
        parity_error = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_outputs",
            32'({sampler_enable, deser_enable, parity_checker_enable,
                 edge_cnt, bit_cnt, data_valid}), 32'd0);
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("idle_hold_edge", 32'(edge_cnt), 32'd0);

        for (int k = 0; k < 9; k++) run_vec(vecs[k]);

        // Glitch start: line low 3 clocks, sampler votes 1 at start LE.
        d0 = d_cnt;
        p0 = p_cnt;
        v0 = v_cnt;
        PAR_EN      = 1'b0;
        Prescale    = 6'd8;
        RX_IN       = 1'b0;
        sampled_bit = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("glitch_in_start", 32'(sampler_enable), 32'd1);
        RX_IN = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        chk("glitch_idle_samp", 32'(sampler_enable), 32'd0);
        chk("glitch_idle_bit", 32'(bit_cnt), 32'd0);
        chk("glitch_idle_edge", 32'(edge_cnt), 32'd0);
        repeat (10) @(posedge CLK);
        #1;
        chk("glitch_deser", 32'(d_cnt - d0), 32'd0);
        chk("glitch_pce", 32'(p_cnt - p0), 32'd0);
        chk("glitch_dv", 32'(v_cnt - v0), 32'd0);

        // Reset asserted in the middle of the data bits.
        RX_IN       = 1'b0;
        sampled_bit = 1'b0;
        @(posedge CLK);
        #1;
        repeat (7) @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1, 8);
        chk("pre_rst_bit", 32'(bit_cnt), 32'd4);
        @(posedge CLK);
        #2;
        v0  = v_cnt;
        RST = 1'b0;
        #1;
        chk("midrst_outputs",
            32'({sampler_enable, deser_enable, parity_checker_enable,
                 edge_cnt, bit_cnt, data_valid}), 32'd0);
        RX_IN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        chk("postrst_idle", 32'({sampler_enable, bit_cnt, edge_cnt}), 32'd0);
        chk("postrst_dv", 32'(v_cnt - v0), 32'd0);

        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
